spi_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one 12-bit SPI transmitter between NUM_REQ requesters.
- Each requester presents a frame with a req/ack handshake. The arbiter drives the transmitter's new_data/data_in and tracks frame completion via its cs output.
- Sits between client logic (sensor/DAC sequencers) and the SPI transmitter, all in the 100 MHz clk domain.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_tx_arbiter_rr_pick.sv | 34 +++
 rtl/spi_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_spi_tx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transmitter arbiter and its helpers.
package spi_pkg;

    localparam int SPI_DATA_W         = 12;
    localparam int LAUNCH_TIMEOUT_DEF = 400;
    localparam int FRAME_TIMEOUT_DEF  = 3000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr, wrapping upward.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        sum   = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                valid = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmitter between NUM_REQ requesters;
// frame completion is tracked through the transmitter's active-low cs.
module spi_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = spi_pkg::SPI_DATA_W,
    parameter int LAUNCH_TIMEOUT = spi_pkg::LAUNCH_TIMEOUT_DEF,
    parameter int FRAME_TIMEOUT  = spi_pkg::FRAME_TIMEOUT_DEF,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic                      spi_new_data,
    output logic [DATA_W-1:0]         spi_data_in,
    input  logic                      spi_cs,
    output logic                      busy,
    output logic [IW-1:0]             grant_id,
    output logic [1:0]                state_dbg
);

    import spi_pkg::*;

    localparam int TMAX = (LAUNCH_TIMEOUT > FRAME_TIMEOUT) ? LAUNCH_TIMEOUT : FRAME_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    arb_state_e          state_q, state_d;
    logic                ok_q, ok_d;
    logic [TW-1:0]       timer_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [DATA_W-1:0]   data_q;
    logic [IW-1:0]       grant_q;
    logic                cs_s1, cs_s2;
    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic [NUM_REQ-1:0]  grant_oh;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake: a requester holds req until it sees its one-cycle ack (sent) or err (aborted);
    // the frame data is captured at grant, so later req_data changes do not affect it.
    always_comb begin
        state_d = state_q;
        ok_d    = ok_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) state_d = LAUNCH;
            end
            LAUNCH: begin
                if (!cs_s2) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(LAUNCH_TIMEOUT - 1)) begin
                    state_d = DONE;
                    ok_d    = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (cs_s2) begin
                    state_d = DONE;
                    ok_d    = 1'b1;
                end else if (timer_q == TW'(FRAME_TIMEOUT - 1)) begin
                    state_d = DONE;
                    ok_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ok_q     <= 1'b0;
            timer_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            grant_q  <= '0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
        end else begin
            cs_s1   <= spi_cs;
            cs_s2   <= cs_s1;
            state_q <= state_d;
            ok_q    <= ok_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != {TW{1'b1}}) begin
                timer_q <= timer_q + 1'b1;
            end
            if (state_q == IDLE && pick_valid) begin
                grant_q <= pick_idx;
                data_q  <= pick_data;
            end
            // The serviced requester drops to lowest priority.
            if (state_q == DONE) begin
                if (grant_q == IW'(NUM_REQ - 1)) rr_ptr_q <= '0;
                else                             rr_ptr_q <= grant_q + 1'b1;
            end
        end
    end

    assign grant_oh     = NUM_REQ'(1) << grant_q;
    assign ack          = (state_q == DONE && ok_q)  ? grant_oh : '0;
    assign err          = (state_q == DONE && !ok_q) ? grant_oh : '0;
    assign spi_new_data = (state_q == LAUNCH);
    assign spi_data_in  = data_q;
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed and randomized checks of spi_tx_arbiter against a queue-based round-robin model
// and a behavioural transmitter that drives cs.
module tb_spi_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 12;
  localparam int LT = 400;
  localparam int FT = 3000;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    err;
  logic             spi_new_data;
  logic [DW-1:0]    spi_data_in;
  logic             spi_cs;
  logic             busy;
  logic [1:0]       grant_id;
  logic [1:0]       state_dbg;

  spi_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .LAUNCH_TIMEOUT(LT), .FRAME_TIMEOUT(FT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .spi_new_data(spi_new_data), .spi_data_in(spi_data_in), .spi_cs(spi_cs),
    .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
  );

  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;
  int cyc = 0;
  int ev_cnt = 0, ev_cyc = 0, ack_cnt = 0, err_cnt = 0;
  int nd_fall_cnt = 0, nd_fall_cyc = 0, nd_rise_cyc = -1;
  int cs_fall_cyc = 0, cs_rise_cyc = 0;
  int tx_mode = 0, tx_phase = 0, tx_cnt = 0;
  int mptr = 0, mgrant = 0;
  logic prev_nd = 1'b0;
  logic [NR-1:0] hold = '0;
  logic [NR-1:0] last_done = '0;
  int grant_log[$];
  logic [DW-1:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // transmitter model: cs falls a few cycles after new_data, rises after a random frame length
  initial begin
    spi_cs = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        spi_cs = 1'b1;
        tx_phase = 0;
      end else begin
        case (tx_phase)
          0: if (spi_new_data && tx_mode != 1) begin
            tx_phase = 1;
            tx_cnt = $urandom_range(0, 3);
          end
          1: if (tx_cnt == 0) begin
            spi_cs = 1'b0;
            cs_fall_cyc = cyc;
            tx_phase = 2;
            tx_cnt = $urandom_range(4, 20);
          end else tx_cnt--;
          default: if (tx_mode != 2) begin
            if (tx_cnt == 0) begin
              spi_cs = 1'b1;
              cs_rise_cyc = cyc;
              tx_phase = 0;
            end else tx_cnt--;
          end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] get_slice(input logic [NR*DW-1:0] v, input int i);
    return DW'(v >> (i * DW));
  endfunction

  function automatic logic [NR*DW-1:0] set_slice(input logic [NR*DW-1:0] v, input int i,
                                                 input logic [DW-1:0] d);
    logic [NR*DW-1:0] m;
    m = (NR*DW)'({DW{1'b1}}) << (i * DW);
    return (v & ~m) | ((NR*DW)'(d) << (i * DW));
  endfunction

  // reference rule: first requester at or after the pointer, wrapping upward
  function automatic int model_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (((v >> ((p + k) % NR)) & NR'(1)) != '0) return (p + k) % NR;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic raise(input int i, input logic [DW-1:0] d);
    req = req | (NR'(1) << i);
    req_data = set_slice(req_data, i, d);
  endtask

  // one clock: sample #1 after the edge, run the scoreboard, let requesters drop on ack/err
  task automatic step();
    logic [NR-1:0]    req_s;
    logic [NR*DW-1:0] data_s;
    logic             rst_s;
    int               g;
    req_s = req;
    data_s = req_data;
    rst_s = rst;
    @(posedge clk); #1;
    cyc++;
    if (rst_s) begin
      mptr = 0;
      exp_q.delete();
    end
    if (spi_new_data && !prev_nd) begin
      g = model_pick(req_s, mptr);
      chk("req_present_at_grant", g >= 0, 1);
      if (g < 0) g = 0;
      mgrant = g;
      grant_log.push_back(int'(grant_id));
      chk("grant_id", grant_id, g);
      chk("launch_data", spi_data_in, get_slice(data_s, g));
      chk("cs_high_at_launch", spi_cs, 1);
      exp_q.push_back(get_slice(data_s, g));
      nd_rise_cyc = cyc;
    end
    if (!spi_new_data && prev_nd && !rst_s) begin
      nd_fall_cnt++;
      nd_fall_cyc = cyc;
    end
    if ((ack | err) != '0) begin
      ev_cnt++;
      ev_cyc = cyc;
      last_done = ack | err;
      chk("ack_err_exclusive", ack & err, 0);
      chk("done_target", ack | err, NR'(1) << mgrant);
      chk("done_has_frame", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("held_data", spi_data_in, exp_q.pop_front());
      if (ack != '0) ack_cnt++;
      else err_cnt++;
      mptr = (mgrant + 1) % NR;
      req = req & ~((ack | err) & ~hold);
    end
    prev_nd = spi_new_data;
  endtask

  task automatic wait_event(input int limit, input string tag);
    int start;
    int n;
    start = ev_cnt;
    n = 0;
    while (ev_cnt == start && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, ev_cnt != start, 1);
  endtask

  task automatic wait_fall(input int limit, input string tag);
    int start;
    int n;
    start = nd_fall_cnt;
    n = 0;
    while (nd_fall_cnt == start && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_launch_accepted"}, nd_fall_cnt != start, 1);
  endtask

  initial begin
    int t0, a0, e0, g0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;
    req_data = '0;

    // reset state
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_new_data", spi_new_data, 0);
    chk("rst_data_in", spi_data_in, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ack_err", {ack, err}, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    repeat (2) step();

    // single request on requester 2
    a0 = ack_cnt;
    raise(2, 12'hA5C);
    step();
    chk("t1_new_data_1cyc", spi_new_data, 1);
    chk("t1_data_in", spi_data_in, 12'hA5C);
    chk("t1_grant_id", grant_id, 2);
    wait_fall(100, "t1");
    chk("t1_drop_after_cs_sync", nd_fall_cyc - cs_fall_cyc, 3);
    wait_event(200, "t1");
    chk("t1_ack_vec", ack, 4'b0100);
    chk("t1_ack_after_cs_rise", ev_cyc - cs_rise_cyc, 3);
    chk("t1_grant_id_done", grant_id, 2);
    repeat (5) step();
    chk("t1_single_ack", ack_cnt - a0, 1);

    // all four held continuously, starting from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    a0 = ack_cnt;
    e0 = err_cnt;
    g0 = grant_log.size();
    hold = 4'hF;
    raise(0, 12'h001);
    raise(1, 12'h002);
    raise(2, 12'h004);
    raise(3, 12'h008);
    for (int f = 0; f < 5; f++) wait_event(300, "t2");
    hold = '0;
    req = '0;
    repeat (5) step();
    chk("t2_frame_count", grant_log.size() - g0, 5);
    for (int f = 0; f < 5; f++) begin
      if (g0 + f < grant_log.size()) chk("t2_order", grant_log[g0 + f], exp_order[f]);
    end
    chk("t2_ack_count", ack_cnt - a0, 5);
    chk("t2_no_err", err_cnt - e0, 0);

    // launch timeout: transmitter never lowers cs
    tx_mode = 1;
    a0 = ack_cnt;
    t0 = cyc;
    raise(1, 12'h3C3);
    wait_event(LT + 50, "t3");
    // req cycle + LT cycles in LAUNCH: err is visible in the cycle LT+1 after req was driven
    chk("t3_err_latency", ev_cyc - t0, LT + 1);
    chk("t3_err_vec", err, 4'b0010);
    chk("t3_no_ack", ack_cnt - a0, 0);
    step();
    chk("t3_busy_falls", busy, 0);
    tx_mode = 0;
    repeat (3) step();

    // stuck frame: cs falls but never rises
    tx_mode = 2;
    raise(2, 12'h5A5);
    wait_fall(100, "t4");
    wait_event(FT + 50, "t4");
    chk("t4_err_latency", ev_cyc - nd_fall_cyc, FT);
    chk("t4_err_vec", last_done & err, 4'b0100);
    tx_mode = 0;
    repeat (40) step();
    raise(1, 12'h777);
    wait_event(200, "t4b");
    chk("t4_recovery_ack", ack, 4'b0010);
    repeat (3) step();

    // reset while waiting for the frame to finish
    raise(3, 12'hBEE);
    wait_fall(100, "t5");
    e0 = ev_cnt;
    rst = 1'b1;
    step();
    chk("t5_busy", busy, 0);
    chk("t5_new_data", spi_new_data, 0);
    chk("t5_data_in", spi_data_in, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_no_ack_err", {ack, err}, 0);
    rst = 1'b0;
    chk("t5_no_done_event", ev_cnt - e0, 0);
    g0 = grant_log.size();
    raise(1, 12'h111);
    wait_event(200, "t5a");
    wait_event(200, "t5b");
    chk("t5_restart_grants", grant_log.size() - g0, 2);
    if (grant_log.size() >= g0 + 2) begin
      chk("t5_first_after_rst", grant_log[g0], 1);
      chk("t5_second_after_rst", grant_log[g0 + 1], 3);
    end
    repeat (3) step();

    // fairness: requester 0 continuous, requester 3 arrives mid-frame
    g0 = grant_log.size();
    hold = 4'b0001;
    raise(0, 12'h0AA);
    step();
    raise(3, 12'h333);
    wait_event(200, "t6a");
    wait_event(200, "t6b");
    hold = '0;
    req = '0;
    repeat (5) step();
    chk("t6_grant_count", grant_log.size() - g0, 2);
    if (grant_log.size() >= g0 + 2) begin
      chk("t6_first", grant_log[g0], 0);
      chk("t6_not_starved", grant_log[g0 + 1], 3);
    end

    // randomized traffic against the model; granted data is scrambled after latch
    e0 = ev_cnt;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (((req >> i) & NR'(1)) == '0 && $urandom_range(0, 9) == 0)
          raise(i, DW'($urandom()));
      end
      if (nd_rise_cyc == cyc) req_data = set_slice(req_data, mgrant, DW'($urandom()));
      step();
    end
    req = '0;
    t0 = 0;
    while (busy && t0 < 200) begin
      step();
      t0++;
    end
    chk("rand_drained", busy, 0);
    chk("rand_enough_frames", (ev_cnt - e0) > 20, 1);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
